// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// small prefetch FIFO, with redirect flush and late-response dropping.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          outstanding;
  logic          drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [63:0]   fifo [DEPTH];
  logic [63:0]   head;

  logic req;
  logic resp;
  logic push;
  logic pop;

  // Byte offset of the target is meaningless for word fetch.
  logic unused;
  assign unused = &{1'b0, redirect_pc_i[1:0]};

  always_comb begin
    req  = !rst_i && start_i && !outstanding
        && (count < FULL) && !redirect_i;
    resp = imem_rvalid_i && outstanding;
    push = resp && !drop && !redirect_i && !rst_i;
    pop  = (count != '0) && inst_ready_i
        && !redirect_i && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= {redirect_pc_i[31:2], 2'b00};
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // A response landing now is simply discarded.
      outstanding <= outstanding && !imem_rvalid_i;
      drop        <= outstanding && !imem_rvalid_i;
    end else begin
      if (req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  // fetch_pc has already advanced past the outstanding request.
  always_ff @(posedge clk_i) begin
    if (push) fifo[wr_ptr] <= {fetch_pc - 32'd4, imem_rdata_i};
  end

  assign head         = fifo[rd_ptr];
  assign imem_req_o   = req;
  assign imem_addr_o  = req ? fetch_pc : 32'h0;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? head[31:0]  : 32'h0;
  assign inst_pc_o    = inst_valid_o ? head[63:32] : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic
// checked against a queue-based model of the fetch stream.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ready;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(DEPTH)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(req),
    .imem_addr_o(addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .inst_valid_o(valid),
    .inst_o(inst),
    .inst_pc_o(pc),
    .inst_ready_i(ready)
  );

  instruction_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC),
    .DEPTH(DEPTH)
  ) u_wrap (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(w_req),
    .imem_addr_o(w_addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .inst_valid_o(w_valid),
    .inst_o(w_inst),
    .inst_pc_o(w_pc),
    .inst_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;
  int cyc;

  // memory model: one slot, response after lat cycles
  bit          busy;
  bit          stale;
  bit          live;
  bit          spur;
  int          mwait;
  int          lat;
  logic [31:0] maddr;

  // fetch stream model
  logic [31:0] exp_pc;
  logic [31:0] q[$];

  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] w_addr_q[$];
  logic [31:0] acc_pc_q[$];
  int          first_vld;
  logic [31:0] first_vld_pc;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    w_addr_q.delete();
    acc_pc_q.delete();
    first_vld    = -1;
    first_vld_pc = 32'hDEAD_BEEF;
  endtask

  task automatic pad();
    while (req_addr_q.size() < 4) req_addr_q.push_back(32'hDEAD_BEEF);
    while (req_cyc_q.size() < 4)  req_cyc_q.push_back(-1);
    while (w_addr_q.size() < 4)   w_addr_q.push_back(32'hDEAD_BEEF);
    while (acc_pc_q.size() < 4)   acc_pc_q.push_back(32'hDEAD_BEEF);
  endtask

  task automatic step(input bit r, input bit s, input bit rd,
                      input logic [31:0] rpc, input bit rdy);
    bit exp_req;
    bit got;
    bit pop_m;
    rst         = r;
    start       = s;
    redirect    = rd;
    redirect_pc = rpc;
    ready       = rdy;
    rvalid      = busy && (mwait == 0);
    rdata       = rvalid ? mem_of(maddr) : $urandom;
    if (!busy && spur && $urandom_range(0, 3) == 0) rvalid = 1'b1;
    #2;
    exp_req = !r && s && !rd && !(busy && !stale) && (q.size() < DEPTH);
    chk("req", req, exp_req);
    chk("addr", addr, exp_req ? exp_pc : 32'h0);
    chk("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pc", pc, q[0]);
      chk("inst", inst, mem_of(q[0]));
    end else begin
      chk("pc", pc, 32'h0);
      chk("inst", inst, 32'h0);
    end
    if (req) begin
      req_addr_q.push_back(addr);
      req_cyc_q.push_back(cyc);
    end
    if (w_req) w_addr_q.push_back(w_addr);
    if (valid && rdy && !rd && !r) acc_pc_q.push_back(pc);
    if (valid && first_vld < 0) begin
      first_vld    = cyc;
      first_vld_pc = pc;
    end
    pop_m = !r && !rd && rdy && (q.size() != 0);
    @(posedge clk);
    got = 1'b0;
    if (busy && rvalid) begin
      busy = 1'b0;
      got  = 1'b1;
    end else if (busy && mwait > 0) begin
      mwait--;
    end
    if (r) begin
      q.delete();
      exp_pc = 32'h0;
      live   = 1'b0;
      stale  = busy;
    end else begin
      if (rd) begin
        q.delete();
        exp_pc = {rpc[31:2], 2'b00};
        live   = 1'b0;
      end else begin
        if (pop_m) void'(q.pop_front());
        if (got && live) q.push_back(maddr);
      end
      if (got) begin
        live  = 1'b0;
        stale = 1'b0;
      end
      if (exp_req) begin
        busy   = 1'b1;
        mwait  = lat - 1;
        maddr  = exp_pc;
        live   = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
  endtask

  initial begin
    int n0;
    total = 0;
    passed = 0;
    cyc = 0;
    busy = 0;
    stale = 0;
    live = 0;
    spur = 0;
    mwait = 0;
    lat = 1;
    maddr = 0;
    exp_pc = 0;
    rst = 1;
    start = 0;
    redirect = 0;
    redirect_pc = 0;
    rvalid = 0;
    rdata = 0;
    ready = 0;
    clear_logs();
    @(posedge clk);
    #1;

    // reset state and basic fetch at latency 1
    do_reset();
    chk("rst_valid", valid, 1'b0);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_w_pc", w_pc | w_inst, 32'h0);
    clear_logs();
    n0 = cyc;
    repeat (8) step(0, 1, 0, 32'h0, 1);
    pad();
    chk("bf_a0", req_addr_q[0], 32'h0);
    chk("bf_a1", req_addr_q[1], 32'h4);
    chk("bf_a2", req_addr_q[2], 32'h8);
    chk("bf_c0", req_cyc_q[0], n0);
    chk("bf_c1", req_cyc_q[1], n0 + 2);
    chk("bf_c2", req_cyc_q[2], n0 + 4);
    chk("bf_vcyc", first_vld, n0 + 2);
    chk("bf_vpc", first_vld_pc, 32'h0);
    chk("wrap_a0", w_addr_q[0], 32'hFFFF_FFFC);
    chk("wrap_a1", w_addr_q[1], 32'h0000_0000);

    // backpressure fills both entries then stalls
    do_reset();
    clear_logs();
    repeat (12) step(0, 1, 0, 32'h0, 0);
    chk("bp_req", req, 1'b0);
    chk("bp_head", pc, 32'h0);
    chk("bp_inst", inst, mem_of(32'h0));
    chk("bp_nreq", req_addr_q.size(), 2);
    repeat (4) step(0, 1, 0, 32'h0, 1);
    pad();
    chk("bp_ord0", acc_pc_q[0], 32'h0);
    chk("bp_ord1", acc_pc_q[1], 32'h4);

    // redirect while a latency-3 request is in flight
    do_reset();
    lat = 3;
    step(0, 1, 0, 32'h0, 1);
    step(0, 1, 1, 32'h103, 1);
    clear_logs();
    repeat (12) step(0, 1, 0, 32'h0, 1);
    pad();
    chk("rd_addr", req_addr_q[0], 32'h100);
    chk("rd_pc", first_vld_pc, 32'h100);

    // redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    for (int i = 0; i < 10 && !(valid && busy && mwait == 0); i++)
      step(0, 1, 0, 32'h0, 0);
    chk("rp_reach", valid, 1'b1);
    step(0, 1, 1, 32'h200, 1);
    chk("rp_valid", valid, 1'b0);
    clear_logs();
    repeat (6) step(0, 1, 0, 32'h0, 1);
    pad();
    chk("rp_addr", req_addr_q[0], 32'h200);
    chk("rp_pc", first_vld_pc, 32'h200);

    // reset with one entry buffered and one request outstanding
    do_reset();
    lat = 1;
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    lat = 3;
    step(0, 1, 0, 32'h0, 0);
    chk("rm_setup", valid, 1'b1);
    step(1, 0, 0, 32'h0, 0);
    chk("rm_req", req, 1'b0);
    chk("rm_addr0", addr, 32'h0);
    chk("rm_valid", valid, 1'b0);
    chk("rm_inst", inst, 32'h0);
    chk("rm_pc0", pc, 32'h0);
    for (int i = 0; i < 10 && busy; i++) step(0, 0, 0, 32'h0, 1);
    chk("rm_drain", valid, 1'b0);
    clear_logs();
    lat = 1;
    repeat (6) step(0, 1, 0, 32'h0, 1);
    pad();
    chk("rm_addr", req_addr_q[0], 32'h0);
    chk("rm_pc", first_vld_pc, 32'h0);

    // random traffic against the model
    spur = 1;
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 4);
      step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           $urandom, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of prefetch buffer entries; the only legal values SHALL be 2 and 4.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: fetch enable; no new memory request is issued while it is low.
REQ-006 The block SHALL have port redirect_i, input, 1 bit: a one-cycle request to redirect fetch (branch/jump).
REQ-007 The block SHALL have port redirect_pc_i, input, 32 bits: the redirect target address.
REQ-008 The block SHALL have port imem_req_o, output, 1 bit: a one-cycle instruction memory read request.
REQ-009 The block SHALL have port imem_addr_o, output, 32 bits: the request address, valid when imem_req_o is 1 and 0 otherwise.
REQ-010 The block SHALL have port imem_rvalid_i, input, 1 bit: the read response strobe, arriving 1 or more cycles after the request.
REQ-011 The block SHALL have port imem_rdata_i, input, 32 bits: the response instruction word.
REQ-012 The block SHALL have port inst_valid_o, output, 1 bit: the buffer head holds a valid instruction.
REQ-013 The block SHALL have port inst_o, output, 32 bits: the head instruction, forwarded to decode, Control and Registers.
REQ-014 The block SHALL have port inst_pc_o, output, 32 bits: the address of the head instruction.
REQ-015 The block SHALL have port inst_ready_i, input, 1 bit: the consumer accepts the head this cycle.

Function
REQ-016 The block SHALL hold state: fetch_pc (32 bits), outstanding (1 bit), drop (1 bit), and a FIFO of DEPTH entries of {pc, inst}, each 64 bits, with a count from 0 to DEPTH.
REQ-017 The block SHALL assert imem_req_o in a cycle exactly when start_i=1, outstanding=0, count<DEPTH and redirect_i=0, with imem_addr_o=fetch_pc in that cycle.
REQ-018 On a request, the block SHALL set outstanding to 1 and advance fetch_pc by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 At most one request SHALL be outstanding; a request SHALL never issue in the same cycle that imem_rvalid_i clears outstanding.
REQ-020 When imem_rvalid_i=1 and outstanding=1, the block SHALL clear outstanding; if drop=0 it SHALL push {request address, imem_rdata_i}, and if drop=1 it SHALL discard the data and clear drop.
REQ-021 The block SHALL ignore imem_rvalid_i when outstanding=0.
REQ-022 Space SHALL be reserved at issue time, so a push SHALL never find the FIFO full.
REQ-023 The output SHALL be registered: inst_valid_o=(count!=0), and inst_o/inst_pc_o SHALL reflect the head entry; there is no rvalid-to-output bypass, so the minimum latency from request to inst_valid_o is L+1 cycles for a memory latency of L.
REQ-024 A pop SHALL occur when inst_valid_o=1 and inst_ready_i=1; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-025 On redirect_i=1 the block SHALL, in one cycle: flush the FIFO (count=0), set fetch_pc to {redirect_pc_i[31:2],2'b00}, set drop=outstanding (or drop=0 if imem_rvalid_i=1 in that cycle, with that response discarded), and ignore any pop.
REQ-026 The cycle after a redirect, inst_valid_o SHALL be 0, and the first request SHALL carry the new target address.
REQ-027 start_i=0 SHALL suppress new requests only: an outstanding response still completes, and the FIFO continues to drain.
REQ-028 When inst_valid_o=0, inst_o and inst_pc_o SHALL be 0.

Reset
REQ-029 When rst_i=1 at a clock edge, the block SHALL set fetch_pc=RESET_PC, count=0, outstanding=0, drop=0, imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0 and inst_pc_o=0.
REQ-030 Reset SHALL take priority over redirect, request and response in the same cycle.
REQ-031 A response arriving after reset SHALL be ignored per REQ-021, including a response to a request issued before reset (reset mid-operation).

Verification
REQ-032 The bench SHALL cover basic fetch: reset, then start_i=1, memory latency 1, inst_ready_i=1 -> requests at 0x0, 0x4, 0x8 in cycles N, N+2, N+4, and inst_pc_o=0x0 with inst_o=mem[0] valid in cycle N+2.
REQ-033 The bench SHALL cover backpressure: inst_ready_i=0 with DEPTH=2 -> exactly 2 responses are buffered, imem_req_o stays 0, and the head is held stable; releasing inst_ready_i drains the entries in order 0x0, 0x4.
REQ-034 The bench SHALL cover redirect during an outstanding request: redirect_i=1 with redirect_pc_i=0x103 while a latency-3 request is outstanding -> the late response is discarded, the next request address is 0x100, and the first valid output has inst_pc_o=0x100.
REQ-035 The bench SHALL cover a redirect in the same cycle as a response and a pop -> count=0, nothing is pushed, and the next request goes to the target.
REQ-036 The bench SHALL cover wrap-around: RESET_PC=32'hFFFF_FFFC -> the request sequence is 0xFFFF_FFFC then 0x0000_0000.
REQ-037 The bench SHALL cover reset mid-fetch: rst_i=1 with one request outstanding and 1 entry buffered -> all outputs are 0 next cycle, and the stale response is ignored.
